// File: rtl/ex_div.sv
// -----------------------------------------------------------------------------
// ex_div -- iterative integer divide unit for the EX stage.
//
// Performs DIV / DIVU / REM / REMU on CPU_WIDTH-bit operands using restoring
// radix-2 division, one quotient bit per clock. Divide-by-zero and the signed
// overflow case (MIN / -1) are resolved at start and retire on the next cycle.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   start_i         request a divide this cycle (honoured only in IDLE)
//   div_op_i        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i      rs1 value
//   divisor_i       rs2 value
//   reg_wr_adder_i  destination register tag, latched with the operands
//   flush_i         abort whatever is in flight; wins over start and completion
//   busy_o          unit not idle
//   stall_req_o     hold upstream stages (combinational)
//   done_o          one-cycle pulse, result_o / reg_wr_adder_o valid
//   result_o        quotient or remainder, holds its last value outside DONE
//   reg_wr_adder_o  tag of the retiring op, holds its last value outside DONE
//   state_dbg_o     current FSM state (00 IDLE, 01 CALC, 10 DONE)
//
// Handshake: a request is taken on a rising edge where the unit is IDLE,
// start_i=1 and flush_i=0. The result is presented in the single cycle where
// done_o=1; there is no back-pressure on the result side, so the consumer
// must sample it in that cycle.
// -----------------------------------------------------------------------------
module ex_div #(
  parameter int CPU_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           div_op_i,
  input  logic [CPU_WIDTH-1:0] dividend_i,
  input  logic [CPU_WIDTH-1:0] divisor_i,
  input  logic [4:0]           reg_wr_adder_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 stall_req_o,
  output logic                 done_o,
  output logic [CPU_WIDTH-1:0] result_o,
  output logic [4:0]           reg_wr_adder_o,
  output logic [1:0]           state_dbg_o
);

  localparam int W     = CPU_WIDTH;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
  localparam logic [W-1:0]     MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Operation context captured at start.
  logic             is_rem_q;
  logic             neg_quo_q;   // negate quotient magnitude at retire
  logic             neg_rem_q;   // negate remainder magnitude at retire
  logic [4:0]       tag_q;
  logic [W-1:0]     divisor_q;   // divisor magnitude
  logic [CNT_W-1:0] cnt_q;

  // Working registers. quo_q starts as the dividend magnitude and shifts
  // quotient bits in from the bottom as dividend bits leave the top.
  logic [W:0]       rem_q;
  logic [W-1:0]     quo_q;

  // Hold registers for the retire-side outputs.
  logic [W-1:0]     result_q;
  logic [4:0]       tag_out_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic         op_signed;
  logic         dividend_neg;
  logic         divisor_neg;
  logic         div_zero;
  logic         sig_ovf;
  logic         special;
  logic         accept;
  logic [W-1:0] abs_dividend;
  logic [W-1:0] abs_divisor;

  always_comb begin
    op_signed    = ~div_op_i[0];
    dividend_neg = op_signed & dividend_i[W-1];
    divisor_neg  = op_signed & divisor_i[W-1];
    // MIN negates to itself, which is still the correct unsigned magnitude.
    abs_dividend = dividend_neg ? (~dividend_i + 1'b1) : dividend_i;
    abs_divisor  = divisor_neg  ? (~divisor_i  + 1'b1) : divisor_i;
    div_zero     = (divisor_i == '0);
    sig_ovf      = op_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
    special      = div_zero | sig_ovf;
    accept       = (state_q == S_IDLE) && start_i && !flush_i;
  end

  // ---------------------------------------------------------------------------
  // Restoring division step
  // ---------------------------------------------------------------------------
  logic [W+1:0] trial;      // shifted remainder minus divisor, sign in MSB
  logic [W:0]   rem_shift;
  logic         sub_ok;
  logic [W:0]   rem_step;
  logic [W-1:0] quo_step;

  always_comb begin
    rem_shift = {rem_q[W-1:0], quo_q[W-1]};
    // rem_q never exceeds the divisor, so its top bit is zero; it is kept in
    // the subtraction so nothing is dropped before the sign test.
    trial     = {rem_q, quo_q[W-1]} - {2'b00, divisor_q};
    sub_ok    = ~trial[W+1];
    rem_step  = sub_ok ? trial[W:0] : rem_shift;
    quo_step  = {quo_q[W-2:0], sub_ok};
  end

  // ---------------------------------------------------------------------------
  // Final sign fix-up and selection
  // ---------------------------------------------------------------------------
  logic [W-1:0] quo_fin;
  logic [W-1:0] rem_fin;
  logic [W-1:0] result_sel;

  always_comb begin
    quo_fin    = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fin    = neg_rem_q ? (~rem_q[W-1:0] + 1'b1) : rem_q[W-1:0];
    result_sel = is_rem_q ? rem_fin : quo_fin;
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Flush overrides acceptance and completion alike.
    if (flush_i) begin
      state_d = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      tag_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      tag_out_q <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        is_rem_q <= div_op_i[1];
        tag_q    <= reg_wr_adder_i;
        cnt_q    <= '0;
        if (div_zero) begin
          // Results are final: quotient all ones, remainder the raw dividend.
          quo_q     <= '1;
          rem_q     <= {1'b0, dividend_i};
          divisor_q <= '0;
          neg_quo_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else if (sig_ovf) begin
          quo_q     <= MIN_NEG;
          rem_q     <= '0;
          divisor_q <= '0;
          neg_quo_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else begin
          quo_q     <= abs_dividend;
          rem_q     <= '0;
          divisor_q <= abs_divisor;
          neg_quo_q <= dividend_neg ^ divisor_neg;
          neg_rem_q <= dividend_neg;
        end
      end else if (state_q == S_CALC && !flush_i) begin
        rem_q <= rem_step;
        quo_q <= quo_step;
        cnt_q <= cnt_q + 1'b1;
      end

      if (state_q == S_DONE) begin
        result_q  <= result_sel;
        tag_out_q <= tag_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o         = (state_q != S_IDLE);
    done_o         = (state_q == S_DONE);
    stall_req_o    = accept || (state_q == S_CALC);
    // Live value during DONE, held copy otherwise.
    result_o       = done_o ? result_sel : result_q;
    reg_wr_adder_o = done_o ? tag_q : tag_out_q;
    state_dbg_o    = state_q;
  end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 CPU_WIDTH, 32, operand and result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start_i  input  1  request a divide this cycle (from ID/EX register).
REQ-005 div_op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 dividend_i  input  CPU_WIDTH  rs1 value.
REQ-007 divisor_i  input  CPU_WIDTH  rs2 value.
REQ-008 reg_wr_adder_i  input  5  destination register tag.
REQ-009 flush_i  input  1  pipeline refresh; abort current operation.
REQ-010 busy_o  output  1  unit not idle.
REQ-011 stall_req_o  output  1  request FLOW_STOP of upstream stages.
REQ-012 done_o  output  1  one-cycle pulse; result_o valid.
REQ-013 result_o  output  CPU_WIDTH  quotient or remainder.
REQ-014 reg_wr_adder_o  output  5  tag latched at start.

Function
REQ-015 FSM states IDLE, CALC, DONE; encoding free.
REQ-016 IDLE: start_i=1 and flush_i=0 latches operands, op, and tag; next state CALC, or DONE for special cases.
REQ-017 Special case divide-by-zero (divisor 0): quotient = all ones, remainder = dividend; goes directly to DONE.
REQ-018 Special case signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): quotient 0x80000000, remainder 0; goes directly to DONE.
REQ-019 Signed ops divide absolute values, negate quotient if operand signs differ, and give the remainder the dividend's sign.
REQ-020 CALC runs restoring radix-2 division, one quotient bit per cycle, exactly CPU_WIDTH cycles via a 6-bit counter, then DONE.
REQ-021 Latency (start accepted at edge N): normal op done_o high in cycle N+33; special case high in cycle N+1.
REQ-022 DONE: done_o=1 and result_o selected by op for exactly one cycle; next state IDLE unconditionally.
REQ-023 result_o and reg_wr_adder_o hold their last value outside DONE; consumers sample only when done_o=1.
REQ-024 busy_o = (state != IDLE).
REQ-025 stall_req_o is combinational: 1 when (IDLE and start_i and not flush_i) or state = CALC; 0 in DONE so upstream resumes in the same cycle the result retires.
REQ-026 start_i while not IDLE is ignored.
REQ-027 flush_i=1 in any state: next state IDLE, no done_o pulse, and start_i in the same cycle is ignored; flush_i has priority over start_i and over counter completion.
REQ-028 Intermediate remainder register is CPU_WIDTH+1 bits; no arithmetic is truncated before final selection.

Reset
REQ-029 rst=1 at a rising edge: state IDLE, counter 0, busy_o=0, done_o=0, stall_req_o=0 (when start_i=0), result_o=0, reg_wr_adder_o=0, internal operands 0.
REQ-030 Reset mid-operation discards the operation with no done_o pulse; rst has priority over flush_i and start_i.

Verification
REQ-031 DIV 20 / 0xFFFFFFFD (-3), tag 5: done_o at N+33 with result_o 0xFFFFFFFA and reg_wr_adder_o 5; REM of the same operands gives 0x00000002.
REQ-032 DIVU 0xFFFFFFFF / 2: result_o 0x7FFFFFFF; REMU gives 1; stall_req_o is high N..N+32 and low at N+33.
REQ-033 DIV 7 / 0: done_o at N+1 with result_o 0xFFFFFFFF; REM 7 / 0 gives 7.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF: result_o 0x80000000 at N+1; REM gives 0.
REQ-035 Flush at N+10, then a new start at N+11: no done_o from the first op, and the second op completes at N+44 with correct value.
REQ-036 rst pulse at N+20 of an op, plus a start_i asserted while busy: unit is idle after reset with outputs 0 and no done_o; the busy-time start produces no result.
